// File: rtl/dump_pkg.sv
// dump_pkg: shared types and constants for the memory dumper.
//   dump_state_t   - controller state encoding
//   BYTES_PER_WORD - bytes emitted per memory word
//   HEADER_BYTES   - bytes in the word-count header
//   word_byte()    - selects byte idx of a word, idx 0 = most significant
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEADER    = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } dump_state_t;

  localparam int unsigned BYTES_PER_WORD = 32'd4;
  localparam int unsigned HEADER_BYTES   = 32'd4;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/memory_dumper_serializer.sv
// word_serializer: loads a 32-bit word and offers it as bytes, MSB first,
// over a valid/ready handshake. Byte and valid are registered and stay
// stable while ready is low.
//   clk, reset    - clock, asynchronous active-low reset
//   load, word    - load a new word (only issued while idle)
//   ready         - downstream accepts the offered byte this cycle
//   data, valid   - offered byte
//   last_accept   - final byte of the word is being accepted this cycle
module word_serializer
  import dump_pkg::*;
#(
  parameter int unsigned NUM_BYTES = BYTES_PER_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last_accept
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 32'd1);

  logic [31:0] word_r;
  logic [1:0]  idx_r;
  logic [7:0]  data_r;
  logic        valid_r;
  logic        accept_s;

  // Handshake decode for the currently offered byte.
  always_comb begin
    accept_s    = valid_r && ready;
    last_accept = accept_s && (idx_r == LAST_IDX);
  end

  // Byte sequencing: the next byte is pre-registered so data is a flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r  <= 32'd0;
      idx_r   <= 2'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      word_r  <= word;
      idx_r   <= 2'd0;
      data_r  <= word_byte(word, 2'd0);
      valid_r <= 1'b1;
    end else if (accept_s) begin
      if (idx_r == LAST_IDX) begin
        idx_r   <= 2'd0;
        data_r  <= 8'd0;
        valid_r <= 1'b0;
      end else begin
        idx_r  <= idx_r + 2'd1;
        data_r <= word_byte(word_r, idx_r + 2'd1);
      end
    end else begin
      idx_r   <= idx_r;
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/memory_dumper.sv
// memory_dumper: on start, reads word_count words from base_addr upward
// and streams them to a byte transmitter, optionally preceded by a
// 4-byte word-count header. All bytes are sent MSB first.
//   clk, reset                  - clock, asynchronous active-low reset
//   start, base_addr, word_count- dump request (accepted in IDLE only)
//   mem_out_addr/valid          - read request, held until mem_out_ready
//   mem_out_data/ready          - read data and one-cycle completion strobe
//   uart_in_data/valid/ready    - byte stream to transmitter
//   busy                        - dump in progress
//   done                        - one-cycle pulse after the last byte
module memory_dumper
  import dump_pkg::*;
#(
  parameter int HEADER_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] word_count,
  output logic [31:0] mem_out_addr,
  output logic        mem_out_valid,
  input  logic [31:0] mem_out_data,
  input  logic        mem_out_ready,
  output logic [7:0]  uart_in_data,
  output logic        uart_in_valid,
  input  logic        uart_in_ready,
  output logic        busy,
  output logic        done
);

  dump_state_t state_r;
  logic [31:0] base_r;
  logic [31:0] count_r;
  logic [31:0] index_r;
  logic [31:0] index_next_s;
  logic [31:0] mem_addr_r;
  logic        mem_valid_r;
  logic        busy_r;
  logic        done_r;
  logic        ser_load_s;
  logic [31:0] ser_word_s;
  logic        ser_last_s;

  // Header and data words share one serializer, so the header is one word wide.
  word_serializer #(.NUM_BYTES(HEADER_BYTES)) u_ser (
    .clk         (clk),
    .reset       (reset),
    .load        (ser_load_s),
    .word        (ser_word_s),
    .ready       (uart_in_ready),
    .data        (uart_in_data),
    .valid       (uart_in_valid),
    .last_accept (ser_last_s)
  );

  // Serializer load: header word on accepted start, memory word on read completion.
  always_comb begin
    ser_load_s   = 1'b0;
    ser_word_s   = 32'd0;
    index_next_s = index_r + 32'd1;
    case (state_r)
      ST_IDLE: begin
        if (start && (HEADER_ENABLE != 0)) begin
          ser_load_s = 1'b1;
          ser_word_s = word_count;
        end else begin
          ser_load_s = 1'b0;
        end
      end
      ST_READ_REQ, ST_READ_WAIT: begin
        if (mem_out_ready) begin
          ser_load_s = 1'b1;
          ser_word_s = mem_out_data;
        end else begin
          ser_load_s = 1'b0;
        end
      end
      default: begin
        ser_load_s = 1'b0;
      end
    endcase
  end

  // Controller state, read request and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      base_r      <= 32'd0;
      count_r     <= 32'd0;
      index_r     <= 32'd0;
      mem_addr_r  <= 32'd0;
      mem_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            base_r  <= base_addr;
            count_r <= word_count;
            index_r <= 32'd0;
            if (HEADER_ENABLE != 0) begin
              state_r <= ST_HEADER;
              busy_r  <= 1'b1;
            end else if (word_count == 32'd0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_READ_REQ;
              busy_r      <= 1'b1;
              mem_valid_r <= 1'b1;
              mem_addr_r  <= base_addr;
            end
          end
        end
        ST_HEADER: begin
          if (ser_last_s) begin
            if (count_r == 32'd0) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_READ_REQ;
              mem_valid_r <= 1'b1;
              mem_addr_r  <= base_r + index_r;
            end
          end
        end
        // A completion already in the request cycle is taken immediately.
        ST_READ_REQ: begin
          if (mem_out_ready) begin
            state_r     <= ST_SEND;
            mem_valid_r <= 1'b0;
          end else begin
            state_r <= ST_READ_WAIT;
          end
        end
        ST_READ_WAIT: begin
          if (mem_out_ready) begin
            state_r     <= ST_SEND;
            mem_valid_r <= 1'b0;
          end
        end
        ST_SEND: begin
          if (ser_last_s) begin
            index_r <= index_next_s;
            if (index_next_s == count_r) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_READ_REQ;
              mem_valid_r <= 1'b1;
              mem_addr_r  <= base_r + index_next_s;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_out_addr  = mem_addr_r;
  assign mem_out_valid = mem_valid_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule
